// File: rtl/combat_pkg.sv
// Shared types and constants for the combat referee.
//  state_e     : match phase (PREFIGHT, FIGHT, GAME_OVER)
//  WIN_*       : winner output codes
//  DEF_*       : default match constants
//  pick_winner : winner code from two final health values
package combat_pkg;

  typedef enum logic [1:0] {
    PREFIGHT  = 2'd0,
    FIGHT     = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned DEF_HEALTH_MAX    = 300;
  localparam int unsigned DEF_DAMAGE        = 100;
  localparam int unsigned DEF_INVINC_FRAMES = 60;
  localparam int unsigned DEF_START_FRAMES  = 90;
  localparam int unsigned DEF_ROUND_FRAMES  = 3600;
  localparam int unsigned DEF_SCREEN_W      = 640;
  localparam int unsigned DEF_W             = 11;
  localparam int unsigned CNT_W             = 12;

  // Higher health wins; equal health (including both at zero) is a draw.
  function automatic logic [1:0] pick_winner(input int unsigned h1, input int unsigned h2);
    if (h1 > h2) begin
      return WIN_P1;
    end else if (h2 > h1) begin
      return WIN_P2;
    end else begin
      return WIN_DRAW;
    end
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter advanced by frame ticks; stops at zero.
//  clk, rst_n : clock, asynchronous active-low reset (count <= RESET_VAL)
//  load       : load load_val (has priority over tick)
//  load_val   : value to load
//  tick       : decrement by one when count is non-zero
//  count      : current count
//  zero       : count == 0
module frame_down_counter #(
  parameter int unsigned CW        = 12,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CW'(RESET_VAL);
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/combat_referee.sv
// Match controller: health, invincibility windows, round phase and winner.
// Optional round timer compiled in with `define ROUND_TIMER_EN.
//  clk, rst_n     : single clock, asynchronous active-low reset
//  v_sync         : falling edge is the frame tick
//  hit_p1/hit_p2  : level, player struck this cycle
//  restart        : asynchronous switch, rising edge restarts the match
//  p1/p2_health   : health 0..HEALTH_MAX
//  p2_bar_x       : left x of p2 bar (SCREEN_W-1-p2_health)
//  p1/p2_invincible, fight_active, game_over, winner, time_left
module combat_referee
  import combat_pkg::*;
#(
  parameter int unsigned HEALTH_MAX    = DEF_HEALTH_MAX,
  parameter int unsigned DAMAGE        = DEF_DAMAGE,
  parameter int unsigned INVINC_FRAMES = DEF_INVINC_FRAMES,
  parameter int unsigned START_FRAMES  = DEF_START_FRAMES,
  parameter int unsigned ROUND_FRAMES  = DEF_ROUND_FRAMES,
  parameter int unsigned SCREEN_W      = DEF_SCREEN_W,
  parameter int unsigned W             = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         v_sync,
  input  logic         hit_p1,
  input  logic         hit_p2,
  input  logic         restart,
  output logic [W-1:0] p1_health,
  output logic [W-1:0] p2_health,
  output logic [W-1:0] p2_bar_x,
  output logic         p1_invincible,
  output logic         p2_invincible,
  output logic         fight_active,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [11:0]  time_left
);

  localparam logic [W-1:0] HMAX = W'(HEALTH_MAX);
  localparam logic [W-1:0] DMG  = W'(DAMAGE);
  localparam logic [W-1:0] XMAX = W'(SCREEN_W - 1);

  // Frame tick and restart edge detection
  logic       vs_q, tick;
  logic [2:0] rs_q;
  logic       restart_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      rs_q <= '0;
    end else begin
      vs_q <= v_sync;
      rs_q <= {rs_q[1:0], restart};
    end
  end

  assign tick         = vs_q & ~v_sync;
  // rs_q[0] is the metastability flop; the edge is taken between the later two.
  assign restart_edge = rs_q[1] & ~rs_q[2];

  // Match state
  state_e       state_q, state_d;
  logic [W-1:0] h1_q, h1_d, h2_q, h2_d, bar_q, bar_d;
  logic [1:0]   win_q, win_d;
  logic [W-1:0] h1_dmg, h2_dmg;
  logic         in_fight, inv1, inv2, acc1, acc2, start_done, timeout;

  logic [CNT_W-1:0] start_cnt, inv1_cnt, inv2_cnt;
  logic             start_zero, inv1_zero, inv2_zero;
  logic             unused_inv_cnt;

  assign in_fight   = (state_q == FIGHT);
  assign inv1       = in_fight & ~inv1_zero;
  assign inv2       = in_fight & ~inv2_zero;
  assign acc1       = in_fight & hit_p1 & ~inv1 & ~restart_edge;
  assign acc2       = in_fight & hit_p2 & ~inv2 & ~restart_edge;
  assign start_done = (state_q == PREFIGHT) & tick & (start_zero | (start_cnt == CNT_W'(1)));
  assign h1_dmg     = (h1_q > DMG) ? h1_q - DMG : '0;
  assign h2_dmg     = (h2_q > DMG) ? h2_q - DMG : '0;
  assign unused_inv_cnt = ^{inv1_cnt, inv2_cnt};

  frame_down_counter #(.CW(CNT_W), .RESET_VAL(START_FRAMES)) u_start_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (restart_edge),
    .load_val (CNT_W'(START_FRAMES)),
    .tick     (tick & (state_q == PREFIGHT)),
    .count    (start_cnt),
    .zero     (start_zero)
  );

  frame_down_counter #(.CW(CNT_W), .RESET_VAL(0)) u_inv1_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (restart_edge | acc1),
    .load_val (restart_edge ? '0 : CNT_W'(INVINC_FRAMES)),
    .tick     (tick & in_fight),
    .count    (inv1_cnt),
    .zero     (inv1_zero)
  );

  frame_down_counter #(.CW(CNT_W), .RESET_VAL(0)) u_inv2_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (restart_edge | acc2),
    .load_val (restart_edge ? '0 : CNT_W'(INVINC_FRAMES)),
    .tick     (tick & in_fight),
    .count    (inv2_cnt),
    .zero     (inv2_zero)
  );

`ifdef ROUND_TIMER_EN
  logic [CNT_W-1:0] round_cnt;
  logic             round_zero;

  frame_down_counter #(.CW(CNT_W), .RESET_VAL(ROUND_FRAMES)) u_round_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (restart_edge | start_done),
    .load_val (CNT_W'(ROUND_FRAMES)),
    .tick     (tick & in_fight),
    .count    (round_cnt),
    .zero     (round_zero)
  );

  assign timeout   = in_fight & tick & (round_zero | (round_cnt == CNT_W'(1)));
  assign time_left = round_cnt;
`else
  assign timeout   = 1'b0;
  assign time_left = '0;
`endif

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    win_d   = win_q;
    if (restart_edge) begin
      state_d = PREFIGHT;
      h1_d    = HMAX;
      h2_d    = HMAX;
      win_d   = WIN_NONE;
    end else begin
      unique case (state_q)
        PREFIGHT: begin
          if (start_done) state_d = FIGHT;
        end
        FIGHT: begin
          if (acc1) h1_d = h1_dmg;
          if (acc2) h2_d = h2_dmg;
          // Hits land before the timeout is judged, so one winner rule covers both endings.
          if ((h1_d == '0) || (h2_d == '0) || timeout) begin
            state_d = GAME_OVER;
            win_d   = pick_winner(32'(h1_d), 32'(h2_d));
          end
        end
        GAME_OVER: ;
        default: state_d = PREFIGHT;
      endcase
    end
    bar_d = XMAX - h2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PREFIGHT;
      h1_q    <= HMAX;
      h2_q    <= HMAX;
      bar_q   <= W'(SCREEN_W - 1 - HEALTH_MAX);
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      bar_q   <= bar_d;
      win_q   <= win_d;
    end
  end

  assign p1_health     = h1_q;
  assign p2_health     = h2_q;
  assign p2_bar_x      = bar_q;
  assign p1_invincible = inv1;
  assign p2_invincible = inv2;
  assign fight_active  = in_fight;
  assign game_over     = (state_q == GAME_OVER);
  assign winner        = win_q;

endmodule

// File: tb/tb_combat_referee.sv
module tb_combat_referee;

  localparam int HMAX  = 300;
  localparam int DMG   = 100;
  localparam int INV   = 4;
  localparam int START = 2;
  localparam int ROUND = 10;
  localparam int SW    = 640;
`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0, hit_p1 = 1'b0, hit_p2 = 1'b0, restart = 1'b0;
  logic [10:0] p1_health, p2_health, p2_bar_x;
  logic        p1_invincible, p2_invincible, fight_active, game_over;
  logic [1:0]  winner;
  logic [11:0] time_left;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  combat_referee #(
    .INVINC_FRAMES (INV),
    .START_FRAMES  (START),
    .ROUND_FRAMES  (ROUND)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .v_sync        (v_sync),
    .hit_p1        (hit_p1),
    .hit_p2        (hit_p2),
    .restart       (restart),
    .p1_health     (p1_health),
    .p2_health     (p2_health),
    .p2_bar_x      (p2_bar_x),
    .p1_invincible (p1_invincible),
    .p2_invincible (p2_invincible),
    .fight_active  (fight_active),
    .game_over     (game_over),
    .winner        (winner),
    .time_left     (time_left)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 prefight, 1 fight, 2 over; counters in frames remaining.
  int m_state, m_h1, m_h2, m_inv1, m_inv2, m_start, m_round, m_win;
  bit m_vs_prev;
  bit [2:0] m_rs;

  function automatic void match_reset();
    m_state = 0; m_h1 = HMAX; m_h2 = HMAX; m_inv1 = 0; m_inv2 = 0;
    m_start = START; m_round = ROUND; m_win = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tk, re, a1, a2, tout;
    if (!rst_n) begin
      m_vs_prev = 1'b0;
      m_rs = '0;
      match_reset();
    end else begin
      tk = m_vs_prev && !v_sync;
      m_vs_prev = v_sync;
      re = m_rs[1] && !m_rs[2];
      m_rs = {m_rs[1:0], restart};
      if (re) begin
        match_reset();
      end else if (m_state == 0) begin
        if (tk) begin
          m_start--;
          if (m_start <= 0) begin
            m_state = 1;
            m_round = ROUND;
          end
        end
      end else if (m_state == 1) begin
        a1 = hit_p1 && (m_inv1 == 0);
        a2 = hit_p2 && (m_inv2 == 0);
        if (tk) begin
          if (m_inv1 > 0) m_inv1--;
          if (m_inv2 > 0) m_inv2--;
          m_round--;
        end
        if (a1) begin m_h1 = (m_h1 > DMG) ? m_h1 - DMG : 0; m_inv1 = INV; end
        if (a2) begin m_h2 = (m_h2 > DMG) ? m_h2 - DMG : 0; m_inv2 = INV; end
        tout = TIMER && tk && (m_round == 0);
        if (m_h1 == 0 || m_h2 == 0 || tout) begin
          m_state = 2;
          m_win = (m_h1 > m_h2) ? 1 : (m_h2 > m_h1) ? 2 : 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!done) begin
      check("p1_health", int'(p1_health), m_h1);
      check("p2_health", int'(p2_health), m_h2);
      check("p2_bar_x", int'(p2_bar_x), SW - 1 - m_h2);
      check("p1_invincible", int'(p1_invincible), int'(m_state == 1 && m_inv1 > 0));
      check("p2_invincible", int'(p2_invincible), int'(m_state == 1 && m_inv2 > 0));
      check("fight_active", int'(fight_active), int'(m_state == 1));
      check("game_over", int'(game_over), int'(m_state == 2));
      check("winner", int'(winner), m_win);
      check("time_left", int'(time_left), TIMER ? m_round : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    v_sync = 1'b1; step(2);
    v_sync = 1'b0; step(2);
  endtask

  task automatic do_restart();
    restart = 1'b1; step(4);
    restart = 1'b0; step(1);
  endtask

  initial begin
    int rs_hold;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("reset p1_health", int'(p1_health), 300);
    check("reset p2_bar_x", int'(p2_bar_x), 339);
    check("reset winner", int'(winner), 0);
    check("reset fight_active", int'(fight_active), 0);

    // Hit during PREFIGHT is ignored; two ticks start the fight
    hit_p1 = 1'b1; frame(); hit_p1 = 1'b0; frame();
    check("prefight fight_active", int'(fight_active), 1);
    check("prefight p1_health", int'(p1_health), 300);

    // Held hit: one accepted hit, invincible for exactly INV ticks
    hit_p1 = 1'b1; step(10); hit_p1 = 1'b0;
    check("held p1_health", int'(p1_health), 200);
    check("held p1_invincible", int'(p1_invincible), 1);
    repeat (3) frame();
    check("inv after 3 ticks", int'(p1_invincible), 1);
    frame();
    check("inv after 4 ticks", int'(p1_invincible), 0);

`ifdef ROUND_TIMER_EN
    repeat (5) frame();
    check("timer not yet over", int'(game_over), 0);
    check("timer time_left 1", int'(time_left), 1);
    frame();
    check("timer game_over", int'(game_over), 1);
    check("timer winner", int'(winner), 2);
    check("timer time_left 0", int'(time_left), 0);
`else
    for (int i = 0; i < 3; i++) begin
      hit_p2 = 1'b1; step(1); hit_p2 = 1'b0; step(1);
      if (i < 2) repeat (INV) frame();
    end
    check("ko p2_health", int'(p2_health), 0);
    check("ko p2_bar_x", int'(p2_bar_x), 639);
    check("ko game_over", int'(game_over), 1);
    check("ko winner", int'(winner), 1);
`endif

    do_restart();
    check("restart p1_health", int'(p1_health), 300);
    check("restart p2_health", int'(p2_health), 300);
    check("restart winner", int'(winner), 0);
    check("restart game_over", int'(game_over), 0);
    check("restart fight_active", int'(fight_active), 0);

    // Simultaneous hits down to a draw
    frame(); frame();
    for (int i = 0; i < 3; i++) begin
      hit_p1 = 1'b1; hit_p2 = 1'b1; step(1);
      hit_p1 = 1'b0; hit_p2 = 1'b0; step(1);
      if (i < 2) repeat (INV) frame();
    end
    check("draw p1_health", int'(p1_health), 0);
    check("draw p2_health", int'(p2_health), 0);
    check("draw winner", int'(winner), 3);
    check("draw game_over", int'(game_over), 1);
    do_restart();

    // Asynchronous reset mid-fight
    frame(); frame();
    hit_p1 = 1'b1; step(1); hit_p1 = 1'b0; step(1);
    #2 rst_n = 1'b0;
    #1;
    check("async p1_health", int'(p1_health), 300);
    check("async p1_invincible", int'(p1_invincible), 0);
    check("async fight_active", int'(fight_active), 0);
    check("async p2_bar_x", int'(p2_bar_x), 339);
    step(2);
    rst_n = 1'b1;

    // Random play
    rs_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(2) == 0) v_sync = ~v_sync;
      hit_p1 = ($urandom_range(7) == 0);
      hit_p2 = ($urandom_range(7) == 0);
      if (rs_hold > 0) begin
        rs_hold--;
        if (rs_hold == 0) restart = 1'b0;
      end else if ($urandom_range(299) == 0) begin
        restart = 1'b1;
        rs_hold = 5;
      end
    end
    step(2);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
